ghash_digit_mul: RTL and testbench

Parametrised, digit-serial GF(2^128) multiplier for the GCM datapath. It processes DIGIT bits of the multiplicand per clock, trading latency for area. It has valid/ready handshakes on input and output. It supports two modes: a plain product Z = X·H, and a GHASH accumulation step Y <= (Y ^ X)·H with an internal accumulator. It sits between the AES-CTR ciphertext stream and the tag-generation logic.

---
 rtl/ghash_digit_mul.sv | 166 ++++++++++++++++
 tb/tb_ghash_digit_mul.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_digit_mul.sv
// Digit-serial GF(2^128) multiplier (GCM bit order) with an optional GHASH accumulator.
// Latency: operands accepted at edge 0 give o_valid from edge NCYC+1 (NCYC = 128/DIGIT).
// Backpressure: o_ready only in IDLE; the result is held in DONE until i_ready.
module ghash_digit_mul #(
  parameter int DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_x,
  input  logic [127:0] i_h,
  input  logic         i_mode,
  input  logic         i_clr,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_result,
  output logic [127:0] o_acc
);

  localparam int NCYC = 128 / DIGIT;
  // The counter must be able to hold NCYC itself (128 when DIGIT = 1).
  localparam logic [7:0] NCYC_CNT = 8'(NCYC);
  // Reduction constant: 0xE1 followed by 120 zero bits, aligned to vector bits 127:120.
  localparam logic [127:0] R_POLY = {8'hE1, 120'd0};

  // Only power-of-two digit widths that divide 128 evenly are supported.
  generate
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 ||
          DIGIT == 16 || DIGIT == 32 || DIGIT == 64 || DIGIT == 128)) begin : g_bad_digit
      $error("ghash_digit_mul: DIGIT must be one of 1,2,4,8,16,32,64,128");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [127:0] z_q;      // partial product
  logic [127:0] v_q;      // H times x^i, advanced one step per consumed bit
  logic [127:0] x_q;      // remaining operand bits, next bit to consume at bit 127
  logic         mode_q;   // operation updates the accumulator when set
  logic [7:0]   cnt;      // compute cycles completed in RUN

  logic [127:0] z_step;
  logic [127:0] v_step;
  logic [127:0] x_shift;
  logic [127:0] y_eff;
  logic         accept;
  logic         run_last;

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign accept   = i_valid & o_ready;
  // All NCYC digits have been folded into Z; the next RUN cycle publishes it.
  assign run_last = (cnt == NCYC_CNT);

  // Clear has priority over the accumulator when combined with a GHASH step.
  assign y_eff = i_clr ? 128'd0 : o_acc;

  // Retire the consumed digit from the operand; with one full-width digit nothing remains.
  generate
    if (DIGIT == 128) begin : g_shift_full
      assign x_shift = 128'd0;
    end else begin : g_shift_part
      assign x_shift = {x_q[127-DIGIT:0], {DIGIT{1'b0}}};
    end
  endgenerate

  // Apply DIGIT bit-serial multiply steps in increasing GCM bit order.
  always_comb begin
    z_step = z_q;
    v_step = v_q;
    for (int j = 0; j < DIGIT; j++) begin
      if (x_q[127-j]) begin
        z_step = z_step ^ v_step;
      end
      v_step = {1'b0, v_step[127:1]} ^ (v_step[0] ? R_POLY : 128'd0);
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)   state_nxt = RUN;
      RUN:  if (run_last) state_nxt = DONE;
      DONE: if (i_ready)  state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture at acceptance, then one digit of multiply work per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q    <= 128'd0;
      v_q    <= 128'd0;
      x_q    <= 128'd0;
      mode_q <= 1'b0;
      cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            v_q    <= i_h;
            x_q    <= i_mode ? (y_eff ^ i_x) : i_x;
            mode_q <= i_mode;
            z_q    <= 128'd0;
            cnt    <= 8'd0;
          end
        end
        RUN: begin
          if (!run_last) begin
            z_q <= z_step;
            v_q <= v_step;
            x_q <= x_shift;
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result and accumulator: clear is honoured only while idle, GHASH steps write Y on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_result <= 128'd0;
      o_acc    <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_clr) begin
            o_acc <= 128'd0;
          end
        end
        RUN: begin
          if (run_last) begin
            o_result <= z_q;
            if (mode_q) begin
              o_acc <= z_q;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_digit_mul.sv
// Directed bench for ghash_digit_mul: GCM vectors, accumulator rules, backpressure, reset, digit widths.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Extra instances with DIGIT = 1, 4, 32, 128 are checked against a bit-serial model.
module tb_ghash_digit_mul;

  localparam logic [127:0] H_TC   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] X_TC   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] P_TC   = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] L_TC   = 128'h00000000000000000000000000000080;
  localparam logic [127:0] G_TC   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] H_ONE  = 128'h80000000000000000000000000000000;
  localparam logic [127:0] R_POLY = {8'hE1, 120'd0};

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_x;
  logic [127:0] i_h;
  logic         i_mode;
  logic         i_clr;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_result;
  logic [127:0] o_acc;

  logic [3:0]   a_valid;
  logic [3:0]   a_rdy_out;
  logic [3:0]   a_vld;
  logic [127:0] a_res [4];
  logic [127:0] a_acc [4];

  int n_cmp  = 0;
  int n_err  = 0;
  int xfers  = 0;

  always #5 clk = ~clk;

  ghash_digit_mul #(.DIGIT(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_x(i_x), .i_h(i_h),
    .i_mode(i_mode), .i_clr(i_clr), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_acc(o_acc)
  );

  ghash_digit_mul #(.DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .i_valid(a_valid[0]), .o_ready(a_rdy_out[0]), .i_x(i_x), .i_h(i_h),
    .i_mode(i_mode), .i_clr(i_clr), .o_valid(a_vld[0]), .i_ready(1'b1),
    .o_result(a_res[0]), .o_acc(a_acc[0])
  );

  ghash_digit_mul #(.DIGIT(4)) dut_d4 (
    .clk(clk), .rst(rst), .i_valid(a_valid[1]), .o_ready(a_rdy_out[1]), .i_x(i_x), .i_h(i_h),
    .i_mode(i_mode), .i_clr(i_clr), .o_valid(a_vld[1]), .i_ready(1'b1),
    .o_result(a_res[1]), .o_acc(a_acc[1])
  );

  ghash_digit_mul #(.DIGIT(32)) dut_d32 (
    .clk(clk), .rst(rst), .i_valid(a_valid[2]), .o_ready(a_rdy_out[2]), .i_x(i_x), .i_h(i_h),
    .i_mode(i_mode), .i_clr(i_clr), .o_valid(a_vld[2]), .i_ready(1'b1),
    .o_result(a_res[2]), .o_acc(a_acc[2])
  );

  ghash_digit_mul #(.DIGIT(128)) dut_d128 (
    .clk(clk), .rst(rst), .i_valid(a_valid[3]), .o_ready(a_rdy_out[3]), .i_x(i_x), .i_h(i_h),
    .i_mode(i_mode), .i_clr(i_clr), .o_valid(a_vld[3]), .i_ready(1'b1),
    .o_result(a_res[3]), .o_acc(a_acc[3])
  );

  // Count completed output transfers of the main instance.
  always @(posedge clk) begin
    if (o_valid && i_ready) xfers <= xfers + 1;
  end

  // Bit-serial reference multiply in GCM bit order.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] z;
    logic [127:0] v;
    z = 128'd0;
    v = h;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ R_POLY;
      else      v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One main-instance operation; returns the result and the edge count from acceptance to o_valid.
  task automatic do_op(input logic [127:0] x, input logic [127:0] h, input logic mode,
                       input logic clr, input logic clr_in_run,
                       output logic [127:0] res, output int lat);
    @(negedge clk);
    chk("ready_before_accept", 128'(o_ready), 128'd1);
    i_x = x; i_h = h; i_mode = mode; i_clr = clr; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_clr   = clr_in_run;
    lat     = 0;
    @(negedge clk);
    while (!o_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    res     = o_result;
    i_clr   = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic run_alt(input int k, input string tag, input logic [127:0] x,
                         input logic [127:0] h, input logic [127:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    i_x = x; i_h = h; i_mode = 1'b0; i_clr = 1'b0;
    a_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    a_valid[k] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!a_vld[k] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_result"}, a_res[k], exp);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] xr;
    logic [127:0] hr;
    int           lat;
    int           xf0;
    int           alt_lat [4];

    alt_lat = '{129, 33, 5, 2};
    rst = 1'b1; i_valid = 1'b0; i_x = '0; i_h = '0; i_mode = 1'b0; i_clr = 1'b0;
    i_ready = 1'b0; a_valid = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_o_ready", 128'(o_ready), 128'd1);
    chk("rst_o_valid", 128'(o_valid), 128'd0);
    chk("rst_o_result", o_result, 128'd0);
    chk("rst_o_acc", o_acc, 128'd0);
    rst = 1'b0;

    // Plain multiply with the GCM test-case key
    do_op(X_TC, H_TC, 1'b0, 1'b0, 1'b0, res, lat);
    chk("plain_result", res, P_TC);
    chk("plain_latency", 128'(lat), 128'd17);
    chk("plain_acc_untouched", o_acc, 128'd0);

    // GHASH chain of GCM test case 2
    do_op(X_TC, H_TC, 1'b1, 1'b1, 1'b0, res, lat);
    chk("ghash1_result", res, P_TC);
    chk("ghash1_acc", o_acc, P_TC);
    do_op(L_TC, H_TC, 1'b1, 1'b0, 1'b0, res, lat);
    chk("ghash2_result", res, G_TC);
    chk("ghash2_acc", o_acc, G_TC);

    // Asynchronous reset while the digit counter is at 3
    @(negedge clk);
    i_x = rand128(); i_h = rand128(); i_mode = 1'b1; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_o_valid", 128'(o_valid), 128'd0);
    chk("arst_o_ready", 128'(o_ready), 128'd1);
    chk("arst_o_result", o_result, 128'd0);
    chk("arst_o_acc", o_acc, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(X_TC, H_TC, 1'b0, 1'b0, 1'b0, res, lat);
    chk("post_rst_result", res, P_TC);
    chk("post_rst_latency", 128'(lat), 128'd17);
    chk("post_rst_acc", o_acc, 128'd0);

    // Clear is ignored while busy; mode 0 leaves Y alone
    do_op(X_TC, H_TC, 1'b1, 1'b1, 1'b0, res, lat);
    chk("acc_seed", o_acc, P_TC);
    xr = rand128();
    do_op(xr, H_ONE, 1'b0, 1'b0, 1'b1, res, lat);
    chk("clr_in_run_result", res, xr);
    chk("clr_in_run_acc", o_acc, P_TC);

    // Clear while idle without an operation
    @(negedge clk);
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    chk("idle_clr_acc", o_acc, 128'd0);

    // Clear has priority over a nonzero Y for a GHASH step
    do_op(X_TC, H_TC, 1'b1, 1'b0, 1'b0, res, lat);
    chk("acc_from_zero", o_acc, P_TC);
    do_op(L_TC, H_TC, 1'b1, 1'b1, 1'b0, res, lat);
    chk("clr_prio_result", res, gf_mul(L_TC, H_TC));
    chk("clr_prio_acc", o_acc, gf_mul(L_TC, H_TC));

    // Identity, zero and random operands, DIGIT = 8
    xr = rand128();
    do_op(xr, H_ONE, 1'b0, 1'b0, 1'b0, res, lat);
    chk("d8_identity", res, xr);
    do_op(rand128(), 128'd0, 1'b0, 1'b0, 1'b0, res, lat);
    chk("d8_zero", res, 128'd0);
    xr = rand128(); hr = rand128();
    do_op(xr, hr, 1'b0, 1'b0, 1'b0, res, lat);
    chk("d8_random", res, gf_mul(xr, hr));

    // Backpressure: result held while i_ready is low, new operands ignored
    @(negedge clk);
    i_x = X_TC; i_h = H_TC; i_mode = 1'b0; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!o_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 128'(lat), 128'd17);
    xf0 = xfers;
    for (int c = 0; c < 10; c++) begin
      chk("bp_o_valid", 128'(o_valid), 128'd1);
      chk("bp_o_result", o_result, P_TC);
      chk("bp_o_ready", 128'(o_ready), 128'd0);
      i_valid = ~i_valid;
      i_x = rand128(); i_h = rand128();
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("bp_release_valid", 128'(o_valid), 128'd0);
    chk("bp_release_ready", 128'(o_ready), 128'd1);
    repeat (3) @(negedge clk);
    chk("bp_one_transfer", 128'(xfers - xf0), 128'd1);
    chk("bp_still_idle", 128'(o_ready), 128'd1);

    // Other digit widths against the reference model
    for (int k = 0; k < 4; k++) begin
      xr = rand128();
      run_alt(k, $sformatf("alt%0d_identity", k), xr, H_ONE, xr, alt_lat[k]);
      run_alt(k, $sformatf("alt%0d_zero", k), rand128(), 128'd0, 128'd0, alt_lat[k]);
      xr = rand128(); hr = rand128();
      run_alt(k, $sformatf("alt%0d_random", k), xr, hr, gf_mul(xr, hr), alt_lat[k]);
      run_alt(k, $sformatf("alt%0d_gcm", k), X_TC, H_TC, P_TC, alt_lat[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
